// File: rtl/prefix_code_serializer_pkg.sv
// Shared codebook and state encoding for the prefix-code serializer
// and the downstream serial decoder bench.
package prefix_code_serializer_pkg;

  localparam int MAX_LEN = 5;
  localparam int REM_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 8;

  localparam logic IDLE_BIT = 1'b0;

  // Entry 3 is listed first: packed index 3 is the MSB slice.
  localparam logic [3:0][MAX_LEN-1:0] CW_TAB = {
    5'b10100, 5'b00100, 5'b00110, 5'b01011
  };

  localparam logic [3:0][REM_W-1:0] LEN_TAB = {
    3'd5, 3'd4, 3'd4, 3'd4
  };

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/prefix_code_serializer_rom.sv
// Symbol to codeword lookup; codeword is returned left-justified
// so the shifter can always send bit MAX_LEN-1 first.
module prefix_code_serializer_rom
  import prefix_code_serializer_pkg::*;
(
  input  logic [1:0]         i_sym,
  output logic [MAX_LEN-1:0] o_cw,
  output logic [REM_W-1:0]   o_len
);

  for (genvar i = 0; i < 4; i++) begin : g_chk
    if (int'(LEN_TAB[i]) < 1 ||
        int'(LEN_TAB[i]) > MAX_LEN) begin : g_bad
      $error("codeword length out of range");
    end
  end

  logic [REM_W-1:0] w_pad;

  assign o_len = LEN_TAB[i_sym];
  assign w_pad = REM_W'(MAX_LEN) - o_len;
  assign o_cw  = CW_TAB[i_sym] << w_pad;

endmodule

// File: rtl/prefix_code_serializer.sv
// Valid/ready symbol input, MSB-first serial codeword output,
// gap-free across back-to-back symbols.
module prefix_code_serializer
  import prefix_code_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic [CNT_W-1:0] sym_count
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] r_shift;
  logic [REM_W-1:0]   r_rem;
  logic               r_bit;
  logic               r_valid;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_cw;
  logic [REM_W-1:0]   w_len;
  logic               w_load;
  logic               w_shift;
  logic               w_last_cyc;

  prefix_code_serializer_rom u_rom (
    .i_sym (sym_in),
    .o_cw  (w_cw),
    .o_len (w_len)
  );

  assign w_last_cyc = (r_state == S_SHIFT) &&
                      (r_rem == REM_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    sym_ready   = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (w_last_cyc) begin
          sym_ready = 1'b1;
          if (sym_valid) w_load = 1'b1;
          else w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_rem   <= '0;
      r_bit   <= IDLE_BIT;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_shift;
      r_last  <= w_last_cyc;
      r_bit   <= w_shift ? r_shift[MAX_LEN-1] : IDLE_BIT;
      // Count on the edge that takes the last bit off the output.
      if (r_valid && r_last) r_cnt <= r_cnt + 1'b1;
      if (w_load) begin
        r_shift <= w_cw;
        r_rem   <= w_len;
      end else if (w_shift) begin
        r_shift <= {r_shift[MAX_LEN-2:0], 1'b0};
        r_rem   <= r_rem - REM_W'(1);
      end
    end
  end

  assign bit_out   = r_bit;
  assign bit_valid = r_valid;
  assign bit_last  = r_last;
  assign sym_count = r_cnt;

endmodule

// File: tb/tb_prefix_code_serializer.sv
// Self-checking bench: codeword table, bit scoreboard and symbol
// rebuild from bit_valid/bit_last.
module tb_prefix_code_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_last;
  logic [7:0] sym_count;

  prefix_code_serializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .sym_count (sym_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic [4:0] bits;
    int         len;
  } vec_t;

  typedef struct {
    logic b;
    logic l;
    int   t;
  } bit_t;

  vec_t       tbl[4];
  bit_t       bq[$];
  logic [1:0] sq[$];

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] exp_cnt  = '0;
  logic [4:0] rb       = '0;
  int         rb_len   = 0;
  logic [4:0] last_word;
  int         last_len;
  logic [1:0] last_sym;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_sym(input logic [1:0] s);
    for (int i = tbl[s].len - 1; i >= 0; i--) begin
      bit_t e;
      e.b = tbl[s].bits[i];
      e.l = (i == 0);
      e.t = cyc + 2;
      bq.push_back(e);
    end
    sq.push_back(s);
  endtask

  task automatic rebuild();
    int dec;
    dec = -1;
    for (int j = 0; j < 4; j++)
      if (rb_len == tbl[j].len && rb == tbl[j].bits) dec = j;
    last_word = rb;
    last_len  = rb_len;
    if (sq.size() == 0) begin
      chk("sym_rebuild_extra", 32'(dec), 32'hFFFF_FFFF);
    end else begin
      last_sym = sq.pop_front();
      chk("sym_rebuild", 32'(dec), 32'(last_sym));
    end
    rb     = '0;
    rb_len = 0;
  endtask

  // One cycle: check outputs at the falling edge, then drive.
  task automatic step(input logic v, input logic [1:0] s,
                      output bit acc);
    bit   exp_v;
    bit   exp_rdy;
    bit_t e;
    @(negedge clk);
    chk("sym_count", sym_count, exp_cnt);
    exp_v = (bq.size() > 0) && (bq[0].t <= cyc);
    chk("bit_valid", bit_valid, exp_v);
    if (exp_v) begin
      e = bq.pop_front();
      chk("bit_out", bit_out, e.b);
      chk("bit_last", bit_last, e.l);
      rb = {rb[3:0], bit_out};
      rb_len++;
      if (e.l) begin
        exp_cnt = exp_cnt + 8'd1;
        rebuild();
      end
    end else begin
      chk("idle_bit_out", bit_out, 1'b0);
      chk("idle_bit_last", bit_last, 1'b0);
    end
    exp_rdy = (bq.size() <= 1);
    chk("sym_ready", sym_ready, exp_rdy);
    acc = v && exp_rdy;
    if (acc) push_sym(s);
    sym_valid = v;
    sym_in    = s;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, a);
  endtask

  task automatic send(input logic [1:0] s);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 20) begin
      step(1'b1, s, a);
      n++;
    end
    if (!a) chk("send_timeout", 0, 1);
  endtask

  initial begin
    bit         a;
    int         n;
    int         sent;
    logic [1:0] cur;
    logic [7:0] c0;

    tbl[0] = '{2'd0, 5'b01011, 4};
    tbl[1] = '{2'd1, 5'b00110, 4};
    tbl[2] = '{2'd2, 5'b00100, 4};
    tbl[3] = '{2'd3, 5'b10100, 5};

    reset_n   = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 2'd0;
    #1;
    chk("rst_bit_out", bit_out, 1'b0);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_bit_last", bit_last, 1'b0);
    chk("rst_count", sym_count, 8'd0);
    chk("rst_ready", sym_ready, 1'b1);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Table: single symbols from idle.
    for (int k = 0; k < 4; k++) begin
      c0 = exp_cnt;
      send(tbl[k].sym);
      idle(8);
      chk("tbl_word", 32'(last_word), 32'(tbl[k].bits));
      chk("tbl_len", 32'(last_len), 32'(tbl[k].len));
      chk("tbl_count", sym_count, c0 + 8'd1);
      if (k == 0) chk("single_sym0_count", sym_count, 8'd1);
    end

    // Back-to-back 3,1,2 with valid held high.
    c0 = exp_cnt;
    send(2'd3);
    send(2'd1);
    send(2'd2);
    idle(8);
    chk("b2b_count", sym_count, c0 + 8'd3);

    // Stall: sym_in changes while not ready.
    send(2'd0);
    a = 0;
    n = 0;
    while (!a && n < 20) begin
      cur = 2'($urandom_range(0, 3));
      step(1'b1, cur, a);
      n++;
    end
    if (!a) chk("stall_timeout", 0, 1);
    idle(8);
    chk("stall_accepted", last_sym, cur);

    // Reset during bit 2 of symbol 3.
    send(2'd3);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bit_out", bit_out, 1'b0);
    chk("mid_rst_bit_valid", bit_valid, 1'b0);
    chk("mid_rst_count", sym_count, 8'd0);
    bq.delete();
    sq.delete();
    exp_cnt = '0;
    rb      = '0;
    rb_len  = 0;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    chk("post_rst_ready", sym_ready, 1'b1);

    // Wrap: 256 x sym 2.
    for (int k = 0; k < 256; k++) send(2'd2);
    idle(8);
    chk("wrap_count", sym_count, 8'd0);

    // Random symbols with random valid gaps.
    sent = 0;
    n    = 0;
    cur  = 2'($urandom_range(0, 3));
    while (sent < 2000 && n < 40000) begin
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, cur, a);
        if (a) begin
          sent++;
          cur = 2'($urandom_range(0, 3));
        end
      end else begin
        step(1'b0, 2'($urandom_range(0, 3)), a);
      end
      n++;
    end
    if (sent < 2000) chk("rand_timeout", 32'(sent), 32'd2000);
    idle(10);
    chk("rand_sq_empty", 32'(sq.size()), 0);
    chk("rand_bq_empty", 32'(bq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
